load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL be the datapath width, taken from riscv_pkg.
REQ-002 clk_i  in  1  SHALL be the single clock.
REQ-003 rstn_i  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 flush_i  in  1  SHALL kill an op not yet accepted.
REQ-005 operationM_i  in  operation_e  SHALL be the decoded op from the EX-MEM register.
REQ-006 rdM_port_i  in  rd_port_t  SHALL be the rd addr/data/valid from EX.
REQ-007 memM_wrt_ena_i  in  1  SHALL be the store enable from EX.
REQ-008 memM_addr_i  in  XLEN  SHALL be the effective address (rs1+imm).
REQ-009 memM_wrt_data_i  in  XLEN  SHALL be the store data (rs2).
REQ-010 dmem_req_o / dmem_we_o  out  1 / 1  SHALL be the memory request and write strobe.
REQ-011 dmem_addr_o  out  XLEN  SHALL be the word-aligned address.
REQ-012 dmem_be_o  out  4  SHALL be the byte enables.
REQ-013 dmem_wdata_o  out  XLEN  SHALL be the lane-replicated write data.
REQ-014 dmem_gnt_i / dmem_rvalid_i  in  1 / 1  SHALL be the grant and read-data-valid.
REQ-015 dmem_rdata_i  in  XLEN  SHALL be the read word.
REQ-016 rdM_port_o  out  rd_port_t  SHALL be the registered writeback port.
REQ-017 stall_o  out  1  SHALL hold upstream stages.
REQ-018 misaligned_o  out  1  SHALL be a one-cycle misaligned-access pulse.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT_R.
REQ-020 IDLE with a memory op (LB/LH/LW/LBU/LHU/SB/SH/SW) and !flush_i SHALL latch op, address, data and rd addr, then go to REQ. stall_o=1 combinationally in that cycle.
REQ-021 IDLE with a non-memory op SHALL register rdM_port_i to rdM_port_o (1-cycle latency). flush_i SHALL force valid=0.
REQ-022 REQ SHALL hold dmem_req_o=1 with stable address, be, we and wdata until dmem_gnt_i.
REQ-023 On grant in REQ: a store SHALL go to IDLE with rdM_port_o.valid=0; a load SHALL go to WAIT_R.
REQ-024 WAIT_R on dmem_rvalid_i SHALL load extracted data into rdM_port_o with valid=1 the next cycle and go to IDLE.
REQ-025 stall_o SHALL equal (state!=IDLE) OR (IDLE AND memory op AND !flush_i).
REQ-026 Load latency with gnt in the first REQ cycle and rvalid one cycle later SHALL be: accept c0, REQ c1, WAIT_R c2, result valid c3. stall_o SHALL be high c0-c2.
REQ-027 dmem_addr_o SHALL be {addr[XLEN-1:2],2'b00}.
REQ-028 off = addr[1:0]. be SHALL be: SB/LB/LBU 0001<<off; SH/LH/LHU 0011<<off; SW/LW 1111.
REQ-029 wdata SHALL be: SB {4{d[7:0]}}; SH {2{d[15:0]}}; SW d.
REQ-030 Load data SHALL be: LB/LBU rdata byte off, sign-/zero-extended; LH/LHU halfword off[1], sign-/zero-extended; LW the whole word.
REQ-031 Misalignment is halfword with off[0]=1, or word with off!=0. It SHALL issue no request, pulse misaligned_o, give rd valid=0, and stay in IDLE.
REQ-032 flush_i in REQ or WAIT_R SHALL be ignored: an issued transaction completes.
REQ-033 dmem_rvalid_i outside WAIT_R and dmem_gnt_i outside REQ SHALL be ignored.
REQ-034 Inputs SHALL be sampled only on acceptance in IDLE and are don't-care while stall_o=1.

Reset
REQ-035 rstn_i low SHALL immediately set state=IDLE and force dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o, rdM_port_o, misaligned_o to 0.
REQ-036 Reset mid-transaction SHALL abandon it; a later stray rvalid SHALL be ignored.

Structure
REQ-037 riscv_pkg SHALL hold XLEN, operation_e, rd_port_t and the new lsu_state_e.
REQ-038 Lane logic (be, replication, extraction, misalign detect) SHALL be the combinational sub-module lsu_align.

Verification
REQ-039 SW addr 0x100, data 0xDEADBEEF, gnt on first REQ cycle -> one req, we=1, be=1111, addr 0x100, stall 2 cycles, no rd valid.
REQ-040 LB addr 0x203, rdata 0x80FFFFFF, gnt immediate, rvalid next cycle -> rd data 0xFFFFFF80 valid at c3. LBU same -> 0x00000080.
REQ-041 SH addr 0x102, data 0x0000ABCD, gnt delayed 3 cycles -> be=1100, wdata 0xABCDABCD held stable 4 cycles.
REQ-042 LW addr 0x101 -> misaligned_o pulse, dmem_req_o never asserted, rd valid 0.
REQ-043 LW accepted, rstn_i low while in WAIT_R, rvalid after reset release -> state IDLE, rd valid stays 0.
REQ-044 ADD with rd x5, data 7 -> rdM_port_o {5,7,1} next cycle. Same op with flush_i=1 -> valid 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types: datapath width, decoded operations, writeback port
// and the load/store unit FSM encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
    OP_LB,  OP_LH,  OP_LW,  OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
  } operation_e;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic            valid;
  } rd_port_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R
  } lsu_state_e;

  function automatic logic is_mem_op(input operation_e op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the load/store unit: byte enables, store-data replication,
// load-data extraction with sign/zero extension, and misalignment detection.
module lsu_align
  import riscv_pkg::*;
(
  input  operation_e      op,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    be         = 4'b0000;
    wdata_rep  = wdata;
    rdata_ext  = rdata;
    misaligned = 1'b0;
    case (op)
      OP_LB, OP_LBU, OP_SB: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = (op == OP_LB) ? {{(XLEN-8){byte_sel[7]}}, byte_sel}
                                  : {{(XLEN-8){1'b0}}, byte_sel};
      end
      OP_LH, OP_LHU, OP_SH: begin
        be         = 4'b0011 << off;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = (op == OP_LH) ? {{(XLEN-16){half_sel[15]}}, half_sel}
                                   : {{(XLEN-16){1'b0}}, half_sel};
        misaligned = off[0];
      end
      OP_LW, OP_SW: begin
        be         = 4'b1111;
        misaligned = (off != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: accepts one memory op at a time, drives a
// req/gnt/rvalid data-memory port and returns load data on a registered rd port.
module load_store_unit
  import riscv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            flush_i,
  input  operation_e      operationM_i,
  input  rd_port_t        rdM_port_i,
  input  logic            memM_wrt_ena_i,
  input  logic [XLEN-1:0] memM_addr_i,
  input  logic [XLEN-1:0] memM_wrt_data_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output rd_port_t        rdM_port_o,
  output logic            stall_o,
  output logic            misaligned_o
);

  lsu_state_e      state, state_next;
  operation_e      op_q, op_sel;
  logic [1:0]      off_q, off_sel;
  logic [4:0]      rd_addr_q;
  logic            start, issue;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_rep, load_data;
  logic            misaligned;

  // Lane logic sees the incoming op while idle and the latched op afterwards.
  assign op_sel  = (state == IDLE) ? operationM_i     : op_q;
  assign off_sel = (state == IDLE) ? memM_addr_i[1:0] : off_q;

  lsu_align u_align (
    .op         (op_sel),
    .off        (off_sel),
    .wdata      (memM_wrt_data_i),
    .rdata      (dmem_rdata_i),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (load_data),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (issue)         state_next = REQ;
      REQ:     if (dmem_gnt_i)    state_next = dmem_we_o ? IDLE : WAIT_R;
      WAIT_R:  if (dmem_rvalid_i) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    start   = (state == IDLE) && is_mem_op(operationM_i) && !flush_i;
    issue   = start && !misaligned;
    stall_o = (state != IDLE) || start;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      op_q         <= OP_NOP;
      off_q        <= 2'b00;
      rd_addr_q    <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      rdM_port_o   <= '0;
      misaligned_o <= 1'b0;
    end else begin
      misaligned_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue) begin
            op_q         <= operationM_i;
            off_q        <= memM_addr_i[1:0];
            rd_addr_q    <= rdM_port_i.addr;
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= memM_wrt_ena_i;
            dmem_addr_o  <= {memM_addr_i[XLEN-1:2], 2'b00};
            dmem_be_o    <= be;
            dmem_wdata_o <= wdata_rep;
            rdM_port_o   <= '0;
          end else if (start) begin
            misaligned_o <= 1'b1;
            rdM_port_o   <= '0;
          end else begin
            rdM_port_o       <= rdM_port_i;
            rdM_port_o.valid <= rdM_port_i.valid && !flush_i;
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
          end
        end
        WAIT_R: begin
          if (dmem_rvalid_i)
            rdM_port_o <= '{addr: rd_addr_q, data: load_data, valid: 1'b1};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios then randomized ops
// checked against a byte-addressed memory model.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            flush_i;
  operation_e      operationM_i;
  rd_port_t        rdM_port_i;
  logic            memM_wrt_ena_i;
  logic [XLEN-1:0] memM_addr_i;
  logic [XLEN-1:0] memM_wrt_data_i;
  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [3:0]      dmem_be_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic            dmem_gnt_i;
  logic            dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;
  rd_port_t        rdM_port_o;
  logic            stall_o;
  logic            misaligned_o;

  load_store_unit dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .flush_i         (flush_i),
    .operationM_i    (operationM_i),
    .rdM_port_i      (rdM_port_i),
    .memM_wrt_ena_i  (memM_wrt_ena_i),
    .memM_addr_i     (memM_addr_i),
    .memM_wrt_data_i (memM_wrt_data_i),
    .dmem_req_o      (dmem_req_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_addr_o     (dmem_addr_o),
    .dmem_be_o       (dmem_be_o),
    .dmem_wdata_o    (dmem_wdata_o),
    .dmem_gnt_i      (dmem_gnt_i),
    .dmem_rvalid_i   (dmem_rvalid_i),
    .dmem_rdata_i    (dmem_rdata_i),
    .rdM_port_o      (rdM_port_o),
    .stall_o         (stall_o),
    .misaligned_o    (misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [7:0] mem [1024];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input operation_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic bit op_store(input operation_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input operation_e op);
    logic [31:0] v;
    int n, base;
    v = '0;
    n = op_size(op);
    base = int'(addr[9:0]);
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem[(base + i) % 1024];
    if ((op == OP_LB || op == OP_LH) && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    int base;
    base = int'(addr[9:2]) * 4;
    return {mem[base+3], mem[base+2], mem[base+1], mem[base]};
  endfunction

  task automatic idle_inputs();
    operationM_i    = OP_NOP;
    rdM_port_i      = '0;
    memM_wrt_ena_i  = 1'b0;
    flush_i         = 1'b0;
    memM_addr_i     = $urandom;
    memM_wrt_data_i = $urandom;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // One memory op from acceptance to completion; gnt/rvalid delays in cycles.
  task automatic mem_op(input operation_e op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input int gnt_dly, input int rv_dly);
    int n, stalls, base;
    bit store;
    logic [3:0]  exp_be;
    logic [31:0] exp_w, exp_ld;
    n     = op_size(op);
    store = op_store(op);
    base  = int'(addr[9:0]);
    exp_be = '0;
    for (int i = 0; i < n; i++) exp_be[int'(addr[1:0]) + i] = 1'b1;
    for (int i = 0; i < 4; i++) exp_w[8*i +: 8] = data[8*(i % n) +: 8];
    exp_ld = ref_load(addr, op);

    operationM_i    = op;
    memM_addr_i     = addr;
    memM_wrt_data_i = data;
    memM_wrt_ena_i  = store;
    rdM_port_i      = '{addr: rd, data: $urandom, valid: 1'b1};
    flush_i         = 1'b0;
    #1;
    if ((base % n) != 0) begin
      check("mis_noreq_c0", dmem_req_o, 1'b0);
      next_cycle();
      idle_inputs();
      check("mis_pulse", misaligned_o, 1'b1);
      check("mis_noreq", dmem_req_o, 1'b0);
      check("mis_rd_valid", rdM_port_o.valid, 1'b0);
      next_cycle();
      check("mis_pulse_end", misaligned_o, 1'b0);
      check("mis_noreq_end", dmem_req_o, 1'b0);
      check("mis_stall_end", stall_o, 1'b0);
    end else begin
      stalls = stall_o ? 1 : 0;
      next_cycle();
      idle_inputs();
      for (int i = 0; i <= gnt_dly; i++) begin
        check("req", dmem_req_o, 1'b1);
        check("we", dmem_we_o, store);
        check("addr", dmem_addr_o, {addr[31:2], 2'b00});
        check("be", dmem_be_o, exp_be);
        if (store) check("wdata", dmem_wdata_o, exp_w);
        if (stall_o) stalls++;
        dmem_rvalid_i = ($urandom % 2) == 1;
        dmem_rdata_i  = $urandom;
        dmem_gnt_i    = (i == gnt_dly);
        next_cycle();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
      end
      check("req_dropped", dmem_req_o, 1'b0);
      if (store) begin
        for (int i = 0; i < n; i++) mem[(base + i) % 1024] = data[8*i +: 8];
        check("st_rd_valid", rdM_port_o.valid, 1'b0);
        check("st_stall_done", stall_o, 1'b0);
        check("st_stall_cycles", stalls, 2 + gnt_dly);
      end else begin
        for (int j = 0; j <= rv_dly; j++) begin
          check("ld_wait_rd_valid", rdM_port_o.valid, 1'b0);
          if (stall_o) stalls++;
          dmem_gnt_i    = ($urandom % 2) == 1;
          dmem_rvalid_i = (j == rv_dly);
          dmem_rdata_i  = (j == rv_dly) ? mem_word(addr) : $urandom;
          next_cycle();
          dmem_gnt_i    = 1'b0;
          dmem_rvalid_i = 1'b0;
        end
        check("ld_result", rdM_port_o, rd_port_t'{addr: rd, data: exp_ld, valid: 1'b1});
        check("ld_stall_done", stall_o, 1'b0);
        check("ld_stall_cycles", stalls, 3 + gnt_dly + rv_dly);
      end
    end
  endtask

  task automatic alu_op(input operation_e op, input logic [4:0] rd, input logic [31:0] data,
                        input bit flush);
    operationM_i = op;
    rdM_port_i   = '{addr: rd, data: data, valid: 1'b1};
    flush_i      = flush;
    #1;
    check("alu_no_stall", stall_o, 1'b0);
    next_cycle();
    idle_inputs();
    if (flush) check("alu_flush_valid", rdM_port_o.valid, 1'b0);
    else       check("alu_wb", rdM_port_o, rd_port_t'{addr: rd, data: data, valid: 1'b1});
    check("alu_noreq", dmem_req_o, 1'b0);
  endtask

  task automatic flushed_mem_op(input operation_e op, input logic [31:0] addr);
    operationM_i    = op;
    memM_addr_i     = addr;
    memM_wrt_ena_i  = op_store(op);
    rdM_port_i      = '{addr: 5'd3, data: $urandom, valid: 1'b1};
    flush_i         = 1'b1;
    #1;
    check("flush_no_stall", stall_o, 1'b0);
    next_cycle();
    idle_inputs();
    check("flush_noreq", dmem_req_o, 1'b0);
    check("flush_rd_valid", rdM_port_o.valid, 1'b0);
    check("flush_no_mis", misaligned_o, 1'b0);
  endtask

  initial begin
    operation_e mem_ops [8];
    operation_e alu_ops [4];
    mem_ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    alu_ops = '{OP_ADD, OP_SUB, OP_XOR, OP_SLL};
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

    rstn_i        = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_req", dmem_req_o, 1'b0);
    check("rst_we", dmem_we_o, 1'b0);
    check("rst_be", dmem_be_o, 4'b0000);
    check("rst_addr", dmem_addr_o, 32'h0);
    check("rst_wdata", dmem_wdata_o, 32'h0);
    check("rst_rd_port", rdM_port_o, 38'h0);
    check("rst_mis", misaligned_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    rstn_i = 1'b1;
    next_cycle();

    // Store word, immediate grant.
    mem_op(OP_SW, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0);
    check("sw_mem_word", mem_word(32'h100), 32'hDEADBEEF);

    // Signed and unsigned byte loads of the top byte of 0x80FFFFFF.
    mem[12'h200] = 8'hFF; mem[12'h201] = 8'hFF; mem[12'h202] = 8'hFF; mem[12'h203] = 8'h80;
    mem_op(OP_LB, 32'h203, 32'h0, 5'd9, 0, 0);
    check("lb_value", rdM_port_o.data, 32'hFFFFFF80);
    mem_op(OP_LBU, 32'h203, 32'h0, 5'd10, 0, 0);
    check("lbu_value", rdM_port_o.data, 32'h00000080);

    // Upper halfword store with a three-cycle grant delay.
    mem_op(OP_SH, 32'h102, 32'h0000ABCD, 5'd0, 3, 0);
    check("sh_wdata", dmem_wdata_o, 32'hABCDABCD);
    check("sh_be", dmem_be_o, 4'b1100);

    // Misaligned word load.
    mem_op(OP_LW, 32'h101, 32'h0, 5'd4, 0, 0);

    // Reset while waiting for read data, then a stray rvalid.
    operationM_i   = OP_LW;
    memM_addr_i    = 32'h300;
    memM_wrt_ena_i = 1'b0;
    rdM_port_i     = '{addr: 5'd7, data: 32'h0, valid: 1'b1};
    next_cycle();
    idle_inputs();
    dmem_gnt_i = 1'b1;
    next_cycle();
    dmem_gnt_i = 1'b0;
    check("rst_mid_waiting", stall_o, 1'b1);
    #2 rstn_i = 1'b0;
    #1;
    check("rst_mid_req", dmem_req_o, 1'b0);
    check("rst_mid_addr", dmem_addr_o, 32'h0);
    check("rst_mid_be", dmem_be_o, 4'b0000);
    check("rst_mid_stall", stall_o, 1'b0);
    next_cycle();
    rstn_i = 1'b1;
    next_cycle();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hFFFFFFFF;
    next_cycle();
    dmem_rvalid_i = 1'b0;
    check("rst_stray_rd_valid", rdM_port_o.valid, 1'b0);
    check("rst_stray_stall", stall_o, 1'b0);
    next_cycle();
    check("rst_stray_rd_valid2", rdM_port_o.valid, 1'b0);

    // Non-memory writeback, plain and flushed.
    alu_op(OP_ADD, 5'd5, 32'd7, 1'b0);
    alu_op(OP_ADD, 5'd5, 32'd7, 1'b1);

    // Randomized mix against the memory model.
    for (int k = 0; k < 60; k++) begin
      int kind;
      operation_e op;
      logic [31:0] addr;
      kind = int'($urandom_range(0, 9));
      op   = mem_ops[$urandom_range(0, 7)];
      addr = {22'h0, 10'($urandom)};
      if (($urandom % 2) == 1) addr = addr & ~32'(op_size(op) - 1);
      if (kind < 2)
        alu_op(alu_ops[$urandom_range(0, 3)], 5'($urandom), $urandom, ($urandom % 4) == 0);
      else if (kind == 2)
        flushed_mem_op(op, addr);
      else
        mem_op(op, addr, $urandom, 5'($urandom_range(1, 31)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
